// File: rtl/rps_punch_capture.sv
// Rock-paper-scissors front end: per-button synchronize/debounce, round sequencing
// (countdown, capture window, reveal), first-press capture and winner decision.

module rps_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic          level;
    logic [CW-1:0] stable_cnt;

    // press is a registered one-cycle pulse on the debounced 0->1 toggle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync       <= 2'b00;
            level      <= 1'b0;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync  <= {sync[0], btn};
            press <= 1'b0;
            if (sync[1] == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_LAST) begin
                level      <= ~level;
                stable_cnt <= '0;
                press      <= ~level;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end
endmodule

module rps_punch_capture #(
    parameter int TICK_DIV        = 25000,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int COUNT_TICKS     = 3,
    parameter int WINDOW_TICKS    = 8,
    parameter int REVEAL_TICKS    = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       start,
    input  logic [2:0] btn_1,
    input  logic [2:0] btn_2,
    output logic [3:0] punch_1,
    output logic [3:0] punch_2,
    output logic [1:0] countdown,
    output logic       window_open,
    output logic [1:0] winner,
    output logic       round_done
);
    localparam int NUM_PLAYERS = 2;
    localparam int NUM_BTNS    = 3;
    localparam int TW = $clog2(TICK_DIV);
    localparam int WW = $clog2(WINDOW_TICKS + 1);
    localparam int RW = $clog2(REVEAL_TICKS + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_COUNT  = 2'd1;
    localparam logic [1:0] S_OPEN   = 2'd2;
    localparam logic [1:0] S_REVEAL = 2'd3;

    logic [1:0] state;

    logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0] btn_raw;
    logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0] press;
    logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0] cap;
    logic [NUM_PLAYERS-1:0][NUM_BTNS-1:0] cap_nxt;

    assign btn_raw[0] = btn_1;
    assign btn_raw[1] = btn_2;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
            rps_btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .CLK  (CLK),
                .RST_N(RST_N),
                .btn  (btn_raw[p][b]),
                .press(press[p][b])
            );
        end
    end

    // Game tick; phase is realigned when a round starts
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                       tick_cnt <= '0;
        else if (state == S_IDLE && start) tick_cnt <= '0;
        else if (tick)                     tick_cnt <= '0;
        else                               tick_cnt <= tick_cnt + 1'b1;
    end

    // Only a single-button press event counts, and only the first one per round
    always_comb begin
        cap_nxt = cap;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (state == S_OPEN && cap[p] == '0 && $onehot(press[p]))
                cap_nxt[p] = press[p];
        end
    end

    // Codes: bit0 scissors, bit1 stone, bit2 paper. The code a beats is a rotated right by one.
    function automatic logic [1:0] decide(input logic [2:0] a, input logic [2:0] b);
        if (a == b)                                decide = 2'b00;
        else if (b == 3'b000 || b == {a[0], a[2:1]}) decide = 2'b01;
        else                                       decide = 2'b10;
    endfunction

    logic          both_held;
    logic [WW-1:0] win_cnt;
    logic [RW-1:0] rev_cnt;

    assign both_held = (cap[0] != '0) && (cap[1] != '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            countdown   <= 2'd0;
            window_open <= 1'b0;
            win_cnt     <= '0;
            rev_cnt     <= '0;
            cap         <= '0;
            punch_1     <= 4'd0;
            punch_2     <= 4'd0;
            winner      <= 2'b00;
            round_done  <= 1'b0;
        end else begin
            round_done <= 1'b0;
            cap        <= cap_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_COUNT;
                        countdown <= 2'(COUNT_TICKS);
                    end
                end
                S_COUNT: begin
                    if (tick) begin
                        if (countdown == 2'd1) begin
                            state       <= S_OPEN;
                            countdown   <= 2'd0;
                            window_open <= 1'b1;
                            win_cnt     <= '0;
                        end else begin
                            countdown <= countdown - 1'b1;
                        end
                    end
                end
                S_OPEN: begin
                    if (tick) win_cnt <= win_cnt + 1'b1;
                    // cap_nxt so a press landing on the closing cycle still shows
                    if (both_held || (tick && win_cnt == WW'(WINDOW_TICKS - 1))) begin
                        state       <= S_REVEAL;
                        window_open <= 1'b0;
                        rev_cnt     <= '0;
                        round_done  <= 1'b1;
                        punch_1     <= {1'b0, cap_nxt[0]};
                        punch_2     <= {1'b0, cap_nxt[1]};
                        winner      <= decide(cap_nxt[0], cap_nxt[1]);
                    end
                end
                S_REVEAL: begin
                    if (tick) begin
                        if (rev_cnt == RW'(REVEAL_TICKS - 1)) begin
                            state   <= S_IDLE;
                            cap     <= '0;
                            punch_1 <= 4'd0;
                            punch_2 <= 4'd0;
                            winner  <= 2'b00;
                        end else begin
                            rev_cnt <= rev_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rps_punch_capture.sv
// Randomized + directed bench for rps_punch_capture against a round-level model
// (first valid press, rock-paper-scissors rules, tick-based phase lengths).

module tb_rps_punch_capture;
    localparam int TD = 4;
    localparam int DB = 3;
    localparam int CT = 3;
    localparam int WT = 4;
    localparam int RT = 2;
    // Press driven at window index k: sync 2, debounce DB, capture 1, exit 1 -> REVEAL seen at k+DB+4
    localparam int EARLY_LAT = DB + 4;
    localparam int TIMEOUT   = WT * TD;
    localparam int KMAX      = 48;
    localparam logic [2:0] SCI = 3'b001;
    localparam logic [2:0] STN = 3'b010;
    localparam logic [2:0] PAP = 3'b100;

    typedef struct {
        logic [2:0] code;
        int         dly;
        logic [2:0] gmask;
        logic [2:0] mmask;
        logic [2:0] late;
        int         late_d;
        logic [2:0] emask;
    } pspec_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       start = 1'b0;
    logic [2:0] btn_1 = 3'b000;
    logic [2:0] btn_2 = 3'b000;
    logic [3:0] punch_1, punch_2;
    logic [1:0] countdown, winner;
    logic       window_open, round_done;

    rps_punch_capture #(
        .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .COUNT_TICKS(CT),
        .WINDOW_TICKS(WT), .REVEAL_TICKS(RT)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .btn_1(btn_1), .btn_2(btn_2),
        .punch_1(punch_1), .punch_2(punch_2), .countdown(countdown),
        .window_open(window_open), .winner(winner), .round_done(round_done)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int         obs_cd[$];
    int         rd_idx, rd_cnt, rev_len;
    logic [3:0] o_p1, o_p2;
    logic [1:0] o_w;
    logic       o_wo;

    function automatic pspec_t ps(input logic [2:0] code, input int dly,
                                  input logic [2:0] gmask = 3'b000, input logic [2:0] mmask = 3'b000,
                                  input logic [2:0] late = 3'b000, input int late_d = 0,
                                  input logic [2:0] emask = 3'b000);
        pspec_t s;
        s.code = code; s.dly = dly; s.gmask = gmask; s.mmask = mmask;
        s.late = late; s.late_d = late_d; s.emask = emask;
        return s;
    endfunction

    // Raw button level at window index k: 2-cycle glitch, 5-cycle multi press, held presses
    function automatic logic [2:0] drive(input pspec_t s, input int k);
        logic [2:0] v;
        v = 3'b000;
        if (k < 2) v = v | s.gmask;
        if (k < 5) v = v | s.mmask;
        if (k >= s.dly) v = v | s.code;
        if (k >= s.late_d) v = v | s.late;
        return v;
    endfunction

    // First single-button press of the window wins the capture; glitches and multi-presses never count
    task automatic model_cap(input pspec_t s, output logic [2:0] cap, output int kc);
        cap = 3'b000;
        kc  = -1;
        if ($countones(s.mmask) == 1) begin cap = s.mmask; kc = 0; end
        if (s.code != 3'b000 && (kc < 0 || s.dly < kc)) begin cap = s.code; kc = s.dly; end
        if (s.late != 3'b000 && (kc < 0 || s.late_d < kc)) begin cap = s.late; kc = s.late_d; end
    endtask

    function automatic logic [1:0] model_win(input logic [2:0] a, input logic [2:0] b);
        if (a == b) return 2'b00;
        if (b == 3'b000) return 2'b01;
        if (a == 3'b000) return 2'b10;
        if ((a == STN && b == SCI) || (a == SCI && b == PAP) || (a == PAP && b == STN)) return 2'b01;
        return 2'b10;
    endfunction

    task automatic expect_round(input pspec_t a, input pspec_t b,
                                output logic [3:0] e1, output logic [3:0] e2, output logic [1:0] ew,
                                output int erd, output int erev);
        logic [2:0] c1, c2;
        int k1, k2;
        model_cap(a, c1, k1);
        model_cap(b, c2, k2);
        e1 = {1'b0, c1};
        e2 = {1'b0, c2};
        ew = model_win(c1, c2);
        erd = (c1 != 3'b000 && c2 != 3'b000) ? EARLY_LAT + ((k1 > k2) ? k1 : k2) : TIMEOUT;
        // window opens on a tick boundary, so reveal ends on the RT-th tick boundary after entry
        erev = (erd / TD + RT) * TD - erd;
    endtask

    task automatic run_round(input pspec_t a, input pspec_t b);
        obs_cd.delete();
        rd_idx = -1; rd_cnt = 0; rev_len = 0;
        o_p1 = 4'd0; o_p2 = 4'd0; o_w = 2'b00; o_wo = 1'b0;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int j = 0; j < 40 && !window_open; j++) begin
            obs_cd.push_back(int'(countdown));
            btn_1 = (j < 5) ? a.emask : 3'b000;
            btn_2 = (j < 5) ? b.emask : 3'b000;
            @(negedge CLK);
        end
        for (int k = 0; k < KMAX; k++) begin
            if (round_done) begin
                rd_cnt++;
                if (rd_idx < 0) begin
                    rd_idx = k; o_p1 = punch_1; o_p2 = punch_2; o_w = winner; o_wo = window_open;
                end
            end
            if (rd_idx >= 0 && rev_len == k - rd_idx &&
                punch_1 === o_p1 && punch_2 === o_p2 && winner === o_w)
                rev_len++;
            btn_1 = drive(a, k);
            btn_2 = drive(b, k);
            @(negedge CLK);
        end
        btn_1 = 3'b000;
        btn_2 = 3'b000;
        repeat (8) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({punch_1, punch_2, countdown, window_open, winner, round_done} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {punch_1, punch_2, countdown, window_open, winner, round_done});
        end
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        checks++;
        if ({punch_1, punch_2, countdown, window_open, winner, round_done} !== 14'd0) begin
            errors++;
            $display("FAIL reset_idle_hold got %h want 0", {punch_1, punch_2, countdown, window_open, winner, round_done});
        end
    endtask

    task automatic test_normal();
        pspec_t a, b;
        logic [3:0] e1, e2; logic [1:0] ew; int erd, erev;
        a = ps(STN, 0);
        b = ps(SCI, 0);
        expect_round(a, b, e1, e2, ew, erd, erev);
        run_round(a, b);
        checks++;
        if (obs_cd.size() !== CT * TD) begin
            errors++; $display("FAIL normal_count_len got %0d want %0d", obs_cd.size(), CT * TD);
        end
        foreach (obs_cd[j]) begin
            checks++;
            if (obs_cd[j] !== CT - j / TD) begin
                errors++; $display("FAIL normal_countdown[%0d] got %0d want %0d", j, obs_cd[j], CT - j / TD);
            end
        end
        checks++;
        if (rd_idx !== erd) begin errors++; $display("FAIL normal_exit got %0d want %0d", rd_idx, erd); end
        checks++;
        if ({o_p1, o_p2, o_w} !== {e1, e2, ew}) begin
            errors++; $display("FAIL normal_result got %b/%b/%b want %b/%b/%b", o_p1, o_p2, o_w, e1, e2, ew);
        end
        checks++;
        if (rd_cnt !== 1) begin errors++; $display("FAIL normal_done_pulses got %0d want 1", rd_cnt); end
        checks++;
        if (o_wo !== 1'b0) begin errors++; $display("FAIL normal_window_closed got %b want 0", o_wo); end
        checks++;
        if (rev_len !== erev) begin errors++; $display("FAIL normal_reveal_len got %0d want %0d", rev_len, erev); end
    endtask

    task automatic test_bounce();
        pspec_t a, b;
        logic [3:0] e1, e2; logic [1:0] ew; int erd, erev;
        a = ps(PAP, 3, PAP);
        b = ps(SCI, 1);
        expect_round(a, b, e1, e2, ew, erd, erev);
        run_round(a, b);
        checks++;
        if (rd_idx !== erd) begin errors++; $display("FAIL bounce_exit got %0d want %0d", rd_idx, erd); end
        checks++;
        if ({o_p1, o_p2, o_w} !== {e1, e2, ew}) begin
            errors++; $display("FAIL bounce_result got %b/%b/%b want %b/%b/%b", o_p1, o_p2, o_w, e1, e2, ew);
        end
    endtask

    task automatic test_conflict();
        pspec_t a, b;
        logic [3:0] e1, e2; logic [1:0] ew; int erd, erev;
        a = ps(STN, 6, 3'b000, SCI | PAP, 3'b000, 0, PAP);
        b = ps(PAP, 0);
        expect_round(a, b, e1, e2, ew, erd, erev);
        run_round(a, b);
        checks++;
        if ({o_p1, o_p2, o_w} !== {e1, e2, ew}) begin
            errors++; $display("FAIL conflict_result got %b/%b/%b want %b/%b/%b", o_p1, o_p2, o_w, e1, e2, ew);
        end
        checks++;
        if (rd_idx !== erd) begin errors++; $display("FAIL conflict_exit got %0d want %0d", rd_idx, erd); end
    endtask

    task automatic test_timeout();
        pspec_t a, b;
        logic [3:0] e1, e2; logic [1:0] ew; int erd, erev;
        a = ps(3'b000, 0);
        b = ps(PAP, 2);
        expect_round(a, b, e1, e2, ew, erd, erev);
        run_round(a, b);
        checks++;
        if (rd_idx !== erd) begin errors++; $display("FAIL timeout_exit got %0d want %0d", rd_idx, erd); end
        checks++;
        if ({o_p1, o_p2, o_w} !== {e1, e2, ew}) begin
            errors++; $display("FAIL timeout_result got %b/%b/%b want %b/%b/%b", o_p1, o_p2, o_w, e1, e2, ew);
        end
        checks++;
        if (rev_len !== erev) begin errors++; $display("FAIL timeout_reveal_len got %0d want %0d", rev_len, erev); end
        b = ps(3'b000, 0);
        expect_round(a, b, e1, e2, ew, erd, erev);
        run_round(a, b);
        checks++;
        if (rd_idx !== erd || rd_cnt !== 1) begin
            errors++; $display("FAIL nopress_exit got %0d/%0d want %0d/1", rd_idx, rd_cnt, erd);
        end
        checks++;
        if ({o_p1, o_p2, o_w} !== {e1, e2, ew}) begin
            errors++; $display("FAIL nopress_result got %b/%b/%b want %b/%b/%b", o_p1, o_p2, o_w, e1, e2, ew);
        end
    endtask

    task automatic test_first_press();
        pspec_t a, b;
        logic [3:0] e1, e2; logic [1:0] ew; int erd, erev;
        a = ps(SCI, 0, 3'b000, 3'b000, PAP, 3);
        b = ps(SCI, 4);
        expect_round(a, b, e1, e2, ew, erd, erev);
        run_round(a, b);
        checks++;
        if ({o_p1, o_p2, o_w} !== {e1, e2, ew}) begin
            errors++; $display("FAIL first_press_result got %b/%b/%b want %b/%b/%b", o_p1, o_p2, o_w, e1, e2, ew);
        end
        checks++;
        if (rd_idx !== erd) begin errors++; $display("FAIL first_press_exit got %0d want %0d", rd_idx, erd); end
        checks++;
        if (rev_len !== erev) begin errors++; $display("FAIL first_press_reveal_len got %0d want %0d", rev_len, erev); end
    endtask

    task automatic test_random();
        logic [2:0] codes [4];
        pspec_t s [2];
        logic [3:0] e1, e2; logic [1:0] ew; int erd, erev;
        codes = '{3'b000, SCI, STN, PAP};
        for (int r = 0; r < 12; r++) begin
            for (int p = 0; p < 2; p++) begin
                s[p] = ps(codes[$urandom_range(0, 3)], int'($urandom_range(0, 7)));
                if ($urandom_range(0, 1) == 1) begin
                    s[p].gmask = codes[$urandom_range(1, 3)];
                    s[p].dly   = int'($urandom_range(3, 7));
                end
            end
            expect_round(s[0], s[1], e1, e2, ew, erd, erev);
            run_round(s[0], s[1]);
            checks++;
            if ({o_p1, o_p2, o_w} !== {e1, e2, ew}) begin
                errors++; $display("FAIL random%0d_result got %b/%b/%b want %b/%b/%b", r, o_p1, o_p2, o_w, e1, e2, ew);
            end
            checks++;
            if (rd_idx !== erd || rd_cnt !== 1) begin
                errors++; $display("FAIL random%0d_exit got %0d/%0d want %0d/1", r, rd_idx, rd_cnt, erd);
            end
            if ({e1, e2, ew} != 10'd0) begin
                checks++;
                if (rev_len !== erev) begin
                    errors++; $display("FAIL random%0d_reveal_len got %0d want %0d", r, rev_len, erev);
                end
            end
        end
    endtask

    task automatic test_reset_midround();
        int bad;
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int j = 0; j < 40 && !window_open; j++) @(negedge CLK);
        checks++;
        if (window_open !== 1'b1) begin errors++; $display("FAIL midrst_open got %b want 1", window_open); end
        btn_1 = STN;
        repeat (8) @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if ({punch_1, punch_2, countdown, window_open, winner, round_done} !== 14'd0) begin
            errors++; $display("FAIL midrst_open_async got %h want 0", {punch_1, punch_2, countdown, window_open, winner, round_done});
        end
        btn_1 = 3'b000;
        @(negedge CLK); RST_N = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge CLK);
            if (window_open !== 1'b0 || countdown !== 2'd0 || round_done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL midrst_stays_idle got %0d active cycles want 0", bad); end

        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int j = 0; j < 40 && !window_open; j++) @(negedge CLK);
        btn_1 = STN;
        for (int j = 0; j < 40 && !round_done; j++) @(negedge CLK);
        checks++;
        if (punch_1 !== {1'b0, STN} || winner !== 2'b01) begin
            errors++; $display("FAIL midrst_reveal_pre got %b/%b want 0010/01", punch_1, winner);
        end
        #2 RST_N = 1'b0;
        #1;
        checks++;
        if (punch_1 !== 4'd0 || winner !== 2'b00) begin
            errors++; $display("FAIL midrst_reveal_async got %b/%b want 0000/00", punch_1, winner);
        end
        btn_1 = 3'b000;
        @(negedge CLK); RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        run_round(ps(3'b000, 0), ps(3'b000, 0));
        checks++;
        if (o_p1 !== 4'd0 || rd_idx !== TIMEOUT) begin
            errors++; $display("FAIL midrst_clean_round got %b/%0d want 0000/%0d", o_p1, rd_idx, TIMEOUT);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_bounce();
        test_conflict();
        test_timeout();
        test_first_press();
        test_random();
        test_reset_midround();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
